// File: rtl/demux4_dispatch_pkg.sv
// arm_pkg: destination select encodings shared by the result-routing blocks
package arm_pkg;
    localparam int NUM_DEST = 4;
    typedef logic [1:0] dest_t;
    localparam dest_t DEST_RF  = 2'd0;
    localparam dest_t DEST_MEM = 2'd1;
    localparam dest_t DEST_PSR = 2'd2;
    localparam dest_t DEST_BR  = 2'd3;
endpackage

// File: rtl/demux4_dispatch_fifo.sv
// dispatch_fifo: single-channel synchronous FIFO; pushes on full and pops on empty are dropped
module dispatch_fifo #(
    parameter int size  = 32,
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            push,
    input  logic [size-1:0] din,
    output logic            full,
    input  logic            pop,
    output logic [size-1:0] dout,
    output logic            empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic [size-1:0] mem_q [DEPTH];
    logic [size-1:0] mem_d [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign full  = count_q == FULL_CNT;
    assign empty = count_q == '0;
    // Storage is never cleared; dout is masked while empty so stale words stay hidden
    assign dout  = empty ? '0 : mem_q[rptr_q];
    always_comb begin
        do_push = push & ~full & ~RST;
        do_pop  = pop & ~empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wptr_q] = din;
        wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
        if (RST) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/demux4_dispatch.sv
// demux4_dispatch: routes a SEL-tagged stream into four independent channel FIFOs.
// Define DEMUX4_DISPATCH_CNT_EN to add the per-channel push counters on port CNT.
module demux4_dispatch
    import arm_pkg::*;
#(
    parameter int size  = 32,
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [1:0]      SEL,
    input  logic [size-1:0] IN,
    output logic [size-1:0] OUT0,
    output logic [size-1:0] OUT1,
    output logic [size-1:0] OUT2,
    output logic [size-1:0] OUT3,
    output logic [3:0]      OUT_VALID,
    input  logic [3:0]      OUT_READY
`ifdef DEMUX4_DISPATCH_CNT_EN
    ,
    output logic [63:0]     CNT
`endif
);
    logic [NUM_DEST-1:0] full, empty, push;
    logic [size-1:0] dout [NUM_DEST];
    // Readiness looks only at the addressed channel, so other stalled channels never block
    assign IN_READY  = ~full[SEL];
    assign OUT_VALID = ~empty;
    assign OUT0 = dout[0];
    assign OUT1 = dout[1];
    assign OUT2 = dout[2];
    assign OUT3 = dout[3];
    for (genvar g = 0; g < NUM_DEST; g++) begin : g_ch
        assign push[g] = IN_VALID & IN_READY & (SEL == dest_t'(g));
        dispatch_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo (
            .CLK  (CLK),
            .RST  (RST),
            .push (push[g]),
            .din  (IN),
            .full (full[g]),
            .pop  (OUT_READY[g]),
            .dout (dout[g]),
            .empty(empty[g])
        );
    end
`ifdef DEMUX4_DISPATCH_CNT_EN
    logic [15:0] cnt_q [NUM_DEST];
    logic [15:0] cnt_d [NUM_DEST];
    always_comb begin
        for (int i = 0; i < NUM_DEST; i++) cnt_d[i] = cnt_q[i] + 16'(push[i]);
    end
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_DEST; i++) cnt_q[i] <= RST ? 16'd0 : cnt_d[i];
    end
    assign CNT = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule

// File: tb/tb_demux4_dispatch.sv
// tb_demux4_dispatch: directed scoreboard bench for demux4_dispatch (CNT checks under DEMUX4_DISPATCH_CNT_EN)
module tb_demux4_dispatch;
    logic        CLK = 1'b0;
    logic        RST, IN_VALID, IN_READY;
    logic [1:0]  SEL;
    logic [31:0] IN, OUT0, OUT1, OUT2, OUT3;
    logic [3:0]  OUT_VALID, OUT_READY;
    int errors = 0;
    int checks = 0;
    logic [31:0] mq [4][$];
`ifdef DEMUX4_DISPATCH_CNT_EN
    logic [63:0] CNT;
    logic [15:0] cnt_m [4] = '{default: 16'd0};
`endif

    demux4_dispatch #(.size(32), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .SEL(SEL), .IN(IN),
        .OUT0(OUT0), .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef DEMUX4_DISPATCH_CNT_EN
        , .CNT(CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, compare against the scoreboard, then retire pops/pushes at the edge
    task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        logic [31:0] o [4];
        logic [3:0] ev;
        logic rdy;
        IN_VALID = v;
        SEL = s;
        IN = v ? d : 'x;
        OUT_READY = r;
        #1;
        o = '{OUT0, OUT1, OUT2, OUT3};
        rdy = mq[s].size() < 2;
        chk("in_ready", 64'(IN_READY), 64'(rdy));
        for (int n = 0; n < 4; n++) begin
            ev[n] = mq[n].size() != 0;
            chk($sformatf("out%0d", n), 64'(o[n]), ev[n] ? 64'(mq[n][0]) : 64'd0);
        end
        chk("out_valid", 64'(OUT_VALID), 64'(ev));
`ifdef DEMUX4_DISPATCH_CNT_EN
        chk("cnt", CNT, {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]});
`endif
        for (int n = 0; n < 4; n++) if (r[n] && ev[n]) void'(mq[n].pop_front());
        if (v && rdy) begin
            mq[s].push_back(d);
`ifdef DEMUX4_DISPATCH_CNT_EN
            cnt_m[s]++;
`endif
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic [1:0] s, input logic [31:0] d, input int cycles);
        IN_VALID = v;
        SEL = s;
        IN = d;
        OUT_READY = 4'b0000;
        RST = 1'b1;
        repeat (cycles) @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int n = 0; n < 4; n++) mq[n].delete();
`ifdef DEMUX4_DISPATCH_CNT_EN
        cnt_m = '{default: 16'd0};
`endif
    endtask

    initial begin
        do_reset(1'b0, 2'd0, 32'h0, 2);
        cycle(0, 0, 'x, 4'b0000);
        // single route to channel 2
        cycle(1, 2, 32'hDEADBEEF, 4'b0000);
        cycle(0, 0, 'x, 4'b0100);
        cycle(0, 0, 'x, 4'b0000);
        // fill channel 1, third push refused, other channel still open
        cycle(1, 1, 32'h11, 4'b0000);
        cycle(1, 1, 32'h22, 4'b0000);
        cycle(1, 1, 32'h33, 4'b0000);
        cycle(0, 3, 'x, 4'b0000);
        cycle(1, 3, 32'h77, 4'b0000);
        // full channel popping the same cycle still refuses a push
        cycle(1, 1, 32'hAA, 4'b0010);
        cycle(0, 0, 'x, 4'b1010);
        cycle(0, 0, 'x, 4'b0000);
        // simultaneous push/pop on channel 0 across pointer wrap
        cycle(1, 0, 32'h50, 4'b0000);
        for (int i = 0; i < 8; i++) cycle(1, 0, 32'h55 + i, 4'b0001);
        cycle(0, 0, 'x, 4'b0001);
        // all four channels pop together; ready on empty channels is ignored
        for (int i = 0; i < 4; i++) cycle(1, 2'(i), 32'hC0 + i, 4'b1111);
        cycle(0, 0, 'x, 4'b1111);
        cycle(0, 0, 'x, 4'b1111);
        // reset mid-operation with a push pending
        cycle(1, 0, 32'hA0, 4'b0000);
        cycle(1, 0, 32'hA1, 4'b0000);
        cycle(1, 3, 32'hB0, 4'b0000);
        cycle(1, 3, 32'hB1, 4'b0000);
        do_reset(1'b1, 2'd1, 32'h99, 1);
        cycle(0, 0, 'x, 4'b0000);
        cycle(0, 1, 'x, 4'b1111);
`ifdef DEMUX4_DISPATCH_CNT_EN
        do_reset(1'b0, 2'd0, 32'h0, 1);
        for (int i = 0; i < 65537; i++) cycle(1, 0, 32'(i), 4'b0001);
        chk("cnt_wrap", CNT, 64'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demux4_dispatch.md
Name: demux4_dispatch

Overview:
- 1-to-4 routing block: the write-side counterpart of the 4:1 operand select mux.
- Accepts one valid/ready result stream tagged with a 2-bit destination select (SEL) and delivers each word to one of four output channels.
- Each output channel has its own small FIFO, so a stalled consumer does not block the other three channels.
- Sits between the execute/writeback result path and four consumers: register file write port, memory write buffer, PSR update, and branch unit.

Parameters:
- size, 32, data width of IN and OUT0..OUT3.
- DEPTH, 2, entries per channel FIFO; must be a power of two and at least 2.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  input word present.
- IN_READY  output  1  block accepts the input word this cycle.
- SEL  input  2  destination channel of the input word (0..3).
- IN  input  size  input data.
- OUT0, OUT1, OUT2, OUT3  output  size  head-of-FIFO data per channel.
- OUT_VALID  output  4  bit n set when channel n's FIFO is non-empty.
- OUT_READY  input  4  bit n set when consumer n takes OUTn this cycle.

Behaviour:
- Interface decided: one clock CLK; RST is synchronous, active-high.
- Reset, on the CLK edge with RST=1:
  - all FIFO counts, read pointers and write pointers go to 0;
  - OUT_VALID=4'b0000; OUT0..OUT3=0; IN_READY=1 the cycle after reset.
- RST overrides all traffic in the same cycle. Words held mid-operation are discarded; no push and no pop occurs on the reset edge.
- IN_READY is combinational: IN_READY = (count[SEL] < DEPTH). It depends only on the selected channel. A push is never accepted on a full FIFO, even when that channel pops in the same cycle (no full-FIFO pass-through).
- Push: IN_VALID & IN_READY on an edge writes IN to FIFO[SEL] at wptr[SEL]; wptr increments modulo DEPTH.
- Pop: OUT_VALID[n] & OUT_READY[n] on an edge advances rptr[n] modulo DEPTH.
- count[n] update per edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop. This is legal whenever 0 < count < DEPTH.
- Latency: a word accepted at edge k appears on OUTn with OUT_VALID[n]=1 after edge k, at the earliest. There is no combinational IN->OUT path.
- OUTn shows FIFO[n][rptr[n]] when OUT_VALID[n]=1, and is forced to 0 otherwise.
- Pops on different channels are independent; all four may pop in the same cycle.
- Ordering: strictly FIFO within each channel. No ordering is guaranteed across channels.
- OUT_READY[n] asserted with OUT_VALID[n]=0 is ignored.
- A data-path X on IN while IN_VALID=0 must not propagate to any output.

Optional Feature:
- DEMUX4_DISPATCH_CNT_EN defined:
  - adds output port CNT, 64 bits wide, holding four 16-bit counters (CNT[16n+15:16n] for channel n);
  - counter n increments on each accepted push with SEL=n and wraps 16'hFFFF -> 0;
  - counters are cleared by RST.
- Macro undefined: port CNT and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package arm_pkg holds:
  - constant NUM_DEST=4 and the 2-bit destination typedef;
  - named destination encodings DEST_RF=0, DEST_MEM=1, DEST_PSR=2, DEST_BR=3.
- Natural sub-module: dispatch_fifo, a single-channel sync FIFO with parameters size and DEPTH and ports CLK, RST, push, din, full, pop, dout, empty. It is instantiated four times, with push gated by SEL decode.

Test Plan:
- Reset then idle: RST high for 2 cycles -> OUT_VALID=0000, OUT0..3=0, IN_READY=1.
- Single route: push IN=32'hDEADBEEF with SEL=2 -> next cycle OUT_VALID=0100 and OUT2=DEADBEEF; OUT_READY=0100 pops it, then OUT_VALID=0000.
- Full/backpressure:
  - hold OUT_READY=0 and push 0x11, 0x22 to SEL=1 -> IN_READY=0 while SEL=1;
  - switching to SEL=3 gives IN_READY=1;
  - releasing OUT_READY[1] returns 0x11 then 0x22 in order.
- Simultaneous push/pop:
  - channel 0 holds 1 word; push 0x55 and pop in the same cycle -> count stays 1 and OUT0 becomes 0x55;
  - repeat for 8 cycles to exercise pointer wrap with DEPTH=2.
- Reset mid-operation: fill channels 0 and 3, assert RST together with IN_VALID=1 -> all FIFOs empty next cycle and the pushed word is lost.
- With DEMUX4_DISPATCH_CNT_EN: 65537 pushes to SEL=0 -> CNT[15:0]=1 and the other counters stay 0.
